ex_flag_branch_stage: RTL

EX_FLAG_BRANCH_STAGE -- requirements
Module: ex_flag_branch_stage

---
 rtl/wisc_pkg.sv | 39 +++
 rtl/branch_cond_eval.sv | 35 +++
 rtl/ex_flag_branch_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/wisc_pkg.sv
// Shared ISA constants for the WISC pipeline: opcodes, branch condition codes
// and the bit positions of the N/V/Z flags, plus the per-opcode flag write mask.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OV     = 3'b110;
    localparam logic [2:0] COND_ALWAYS = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    // Which NVZ bits an opcode may overwrite; every opcode with bit 3 set writes none.
    function automatic logic [2:0] flag_write_mask(input logic [3:0] op);
        logic [2:0] mask;
        case (op)
            OP_ADD, OP_SUB:                 mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
            OP_RED, OP_PADDSB:              mask = 3'b000;
            default:                        mask = 3'b000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator: decides whether a conditional
// branch is taken from the architectural NVZ flags.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic n_s;
    logic v_s;
    logic z_s;

    assign n_s = flags[FLAG_N];
    assign v_s = flags[FLAG_V];
    assign z_s = flags[FLAG_Z];

    // Condition-code decode.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:     taken = ~z_s;
            COND_EQ:     taken = z_s;
            COND_GT:     taken = ~z_s & ~n_s;
            COND_LT:     taken = n_s;
            COND_GE:     taken = z_s | (~z_s & ~n_s);
            COND_LE:     taken = n_s | z_s;
            COND_OV:     taken = v_s;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_flag_branch_stage.sv
// EX-stage tail: updates the NVZ flag register, resolves branches against the
// current flags and registers the EX/MEM payload and redirect request.
module ex_flag_branch_stage
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_nvz,
    input  logic [3:0]  dst_reg,
    input  logic        reg_wr_in,
    input  logic        is_branch,
    input  logic [2:0]  cond,
    input  logic [15:0] branch_target,
    input  logic [15:0] pc_plus2,
    output logic        mem_valid,
    output logic [15:0] mem_result,
    output logic [3:0]  mem_dst,
    output logic        mem_reg_wr,
    output logic [2:0]  flags_q,
    output logic        redirect,
    output logic [15:0] redirect_pc
);

    logic        mem_valid_r,   mem_valid_s;
    logic [15:0] mem_result_r,  mem_result_s;
    logic [3:0]  mem_dst_r,     mem_dst_s;
    logic        mem_reg_wr_r,  mem_reg_wr_s;
    logic [2:0]  flags_r,       flags_s;
    logic        redirect_r,    redirect_s;
    logic [15:0] redirect_pc_r, redirect_pc_s;
    logic        taken_s;
    logic [2:0]  flag_mask_s;

    branch_cond_eval u_cond (
        .flags (flags_r),
        .cond  (cond),
        .taken (taken_s)
    );

    assign flag_mask_s = flag_write_mask(opcode);

    // Next-state selection; everything holds unless a case below overrides it.
    always_comb begin
        mem_valid_s   = mem_valid_r;
        mem_result_s  = mem_result_r;
        mem_dst_s     = mem_dst_r;
        mem_reg_wr_s  = mem_reg_wr_r;
        flags_s       = flags_r;
        redirect_s    = 1'b0;
        redirect_pc_s = redirect_pc_r;
        if (flush) begin
            mem_valid_s  = 1'b0;
            mem_reg_wr_s = 1'b0;
        end else if (stall) begin
            mem_valid_s  = mem_valid_r;
        end else if (!in_valid) begin
            mem_valid_s  = 1'b0;
            mem_reg_wr_s = 1'b0;
        end else begin
            mem_valid_s  = 1'b1;
            mem_dst_s    = dst_reg;
            mem_reg_wr_s = reg_wr_in;
            // Branch-and-link writes the return address instead of the ALU value.
            if (is_branch && reg_wr_in) begin
                mem_result_s = pc_plus2;
            end else begin
                mem_result_s = alu_result;
            end
            flags_s = (flags_r & ~flag_mask_s) | (alu_nvz & flag_mask_s);
            if (is_branch && taken_s) begin
                redirect_s    = 1'b1;
                redirect_pc_s = branch_target;
            end else begin
                redirect_s    = 1'b0;
            end
        end
    end

    // State registers with synchronous reset taking priority over stall/flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_r   <= 1'b0;
            mem_result_r  <= 16'h0000;
            mem_dst_r     <= 4'h0;
            mem_reg_wr_r  <= 1'b0;
            flags_r       <= 3'b000;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 16'h0000;
        end else begin
            mem_valid_r   <= mem_valid_s;
            mem_result_r  <= mem_result_s;
            mem_dst_r     <= mem_dst_s;
            mem_reg_wr_r  <= mem_reg_wr_s;
            flags_r       <= flags_s;
            redirect_r    <= redirect_s;
            redirect_pc_r <= redirect_pc_s;
        end
    end

    assign mem_valid   = mem_valid_r;
    assign mem_result  = mem_result_r;
    assign mem_dst     = mem_dst_r;
    assign mem_reg_wr  = mem_reg_wr_r;
    assign flags_q     = flags_r;
    assign redirect    = redirect_r;
    assign redirect_pc = redirect_pc_r;

endmodule
